lsu_sequencer: RTL and testbench
================================

Name: lsu_sequencer

Overview:
Load/store sequencer between the CPU memory stage and the data bus. It accepts one load/store request at a time and drives word-aligned bus beats with byte write enables. Accesses that cross a word boundary are split into two beats. Read data is merged, aligned, masked and sign/zero-extended, then returned as a one-cycle response while the pipeline stalls on o_busy.

Parameters:
ALLOW_MISALIGNED, 1, 1: split word-crossing accesses into two beats; 0: word-crossing access returns an error with no bus traffic

Ports:
i_clk  input  1  clock
i_rst_n  input  1  synchronous reset, active-low
i_req_valid  input  1  request present
o_req_ready  output  1  sequencer can accept (high only in IDLE)
i_req_we  input  1  1=store, 0=load
i_req_addr  input  32  byte address
i_req_wdata  input  32  store data, right-justified
i_req_length  input  2  00=byte, 01=half, 10=word, 11=illegal
i_req_signed  input  1  sign-extend load result
o_busy  output  1  request accepted and not yet responded
o_bus_valid  output  1  bus beat valid
i_bus_ready  input  1  bus accepts beat
o_bus_addr  output  32  word-aligned address (bits [1:0]=00)
o_bus_we  output  4  byte write enables (0000 for reads)
o_bus_wdata  output  32  lane-aligned store data
i_bus_rvalid  input  1  read data valid
i_bus_rdata  input  32  read data
o_rsp_valid  output  1  one-cycle completion pulse
o_rsp_rdata  output  32  load result (0 for stores/errors)
o_rsp_err  output  1  illegal length or disallowed misalignment

Behaviour:
- Synchronous active-low reset: state IDLE, all outputs 0 except o_req_ready=1. Reset mid-transaction abandons it with no response. An i_bus_rvalid arriving later is ignored.
- Acceptance: i_req_valid && o_req_ready. All request fields are registered at acceptance. Offset = addr[1:0].
- Byte mask M = 0001/0011/1111 for lengths 00/01/10, shifted left by offset into 8 bits. M[3:0] gives beat0 enables; M[7:4] gives beat1 enables. Beat1 is needed iff M[7:4]!=0.
- Store data: i_req_wdata rotated left by 8*offset. The same word is driven on both beats.
- States: IDLE -> (error ? RESP : REQ0). REQ0 -> on i_bus_ready: store ? (beat1 ? REQ1 : RESP) : WAIT0. WAIT0 -> on i_bus_rvalid: beat1 ? REQ1 : RESP. REQ1 -> on i_bus_ready: store ? RESP : WAIT1. WAIT1 -> on i_bus_rvalid: RESP. RESP -> IDLE unconditionally.
- Errors: length=11, or beat1 needed with ALLOW_MISALIGNED=0. Goes directly to RESP with o_rsp_err=1 and no bus beat.
- REQ0 drives o_bus_addr = {addr[31:2],00}. REQ1 drives that address +4, wrapping 0xFFFFFFFC -> 0x00000000. o_bus_valid is high only in REQ0/REQ1. Address, enables and data stay stable until i_bus_ready.
- Reads: o_bus_we=0000, with the same byte mask used internally. Merged word takes lanes >= offset from beat0 and lanes < offset from beat1 (all lanes from beat0 if single-beat). The merge is rotated right by 8*offset and masked to length. Sign bit is bit7 (byte) or bit15 (half); upper bits are filled when i_req_signed.
- i_bus_rvalid outside WAIT0/WAIT1 is ignored. Only one beat is outstanding at a time.
- o_rsp_valid is high exactly one cycle in RESP, with o_rsp_rdata/o_rsp_err valid. o_busy is high from the cycle after acceptance through RESP. o_req_ready = (state==IDLE).
- Latency, with bus ready and rvalid one cycle after acceptance:
  - aligned load: accept at c0, beat at c1, rvalid at c2, response at c3
  - aligned store: response at c2
  - illegal request: response at c1

Test Plan:
- Aligned lw at 0x00001000, i_bus_rdata=0xDEADBEEF -> one beat, addr 0x1000, we 0000, o_rsp_rdata=0xDEADBEEF, response 3 cycles after acceptance.
- Signed lb at 0x00001003, rdata=0x80123456 -> 0xFFFFFF80; same access unsigned -> 0x00000080; signed lh at 0x1002 -> 0xFFFF8012.
- Misaligned lw at 0x1002, beat0 rdata=0xDDCCBBAA, beat1 rdata=0x44332211 -> beats at 0x1000 then 0x1004, o_rsp_rdata=0x2211DDCC; with ALLOW_MISALIGNED=0 -> o_rsp_err=1, no o_bus_valid.
- Misaligned sh at 0x1003, wdata=0x0000BEEF -> beat0 addr 0x1000 we 1000 wdata 0xEF0000BE; beat1 addr 0x1004 we 0001; response after beat1 accepted.
- i_bus_ready low for 5 cycles during REQ0 -> addr/we/wdata held constant, o_busy high, o_req_ready low; length=11 -> o_rsp_err=1 one cycle after acceptance, no bus beat.
- Reset asserted while in WAIT0 -> IDLE next cycle, no o_rsp_valid; a stale i_bus_rvalid afterwards produces no response and no state change.

Source files
------------

// File: rtl/lsu_sequencer.sv
// Load/store sequencer: one request at a time, split into up to two word-aligned bus beats.
// Latency: aligned load 3 cycles, aligned store 2 cycles, rejected request 1 cycle after acceptance.
// Backpressure: o_req_ready only in IDLE; beats are held stable until i_bus_ready.
module lsu_sequencer #(
  parameter bit ALLOW_MISALIGNED = 1'b1
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic        i_req_we,
  input  logic [31:0] i_req_addr,
  input  logic [31:0] i_req_wdata,
  input  logic [1:0]  i_req_length,
  input  logic        i_req_signed,
  output logic        o_busy,
  output logic        o_bus_valid,
  input  logic        i_bus_ready,
  output logic [31:0] o_bus_addr,
  output logic [3:0]  o_bus_we,
  output logic [31:0] o_bus_wdata,
  input  logic        i_bus_rvalid,
  input  logic [31:0] i_bus_rdata,
  output logic        o_rsp_valid,
  output logic [31:0] o_rsp_rdata,
  output logic        o_rsp_err
);

  typedef enum logic [2:0] {
    S_IDLE, S_REQ0, S_WAIT0, S_REQ1, S_WAIT1, S_RESP
  } state_t;

  state_t      state_q;
  logic        we_q, signed_q;
  logic [1:0]  off_q, len_q;
  logic [3:0]  hi_mask_q;
  logic [31:0] rd0_q;

  logic        bus_valid_q, rsp_valid_q, rsp_err_q, busy_q, req_ready_q;
  logic [31:0] bus_addr_q, bus_wdata_q, rsp_rdata_q;
  logic [3:0]  bus_we_q;

  logic [3:0]  len_mask_d;
  logic [7:0]  mask_d;
  logic [31:0] wdata_d;
  logic        err_d;
  logic [1:0]  wlane_d;

  logic [31:0] src0_d, merged_d, rot_d, load_res_d;
  logic [1:0]  rlane_d;

  // Request decode: byte mask spanning both beats, lane-rotated store data, error detection.
  always_comb begin
    len_mask_d = 4'b0000;
    wlane_d    = 2'b00;
    wdata_d    = 32'h0;
    case (i_req_length)
      2'b00:   len_mask_d = 4'b0001;
      2'b01:   len_mask_d = 4'b0011;
      2'b10:   len_mask_d = 4'b1111;
      default: len_mask_d = 4'b0000;
    endcase
    mask_d = {4'b0000, len_mask_d} << i_req_addr[1:0];
    for (int i = 0; i < 4; i++) begin
      wlane_d = 2'(i) - i_req_addr[1:0];
      wdata_d[8*i +: 8] = i_req_wdata[8*wlane_d +: 8];
    end
    err_d = (i_req_length == 2'b11) || (!ALLOW_MISALIGNED && (mask_d[7:4] != 4'b0000));
  end

  // Load result: merge beats by lane, rotate the addressed bytes down to bit 0, then mask and extend.
  always_comb begin
    rlane_d  = 2'b00;
    merged_d = 32'h0;
    rot_d    = 32'h0;
    src0_d   = (state_q == S_WAIT1) ? rd0_q : i_bus_rdata;
    for (int i = 0; i < 4; i++) begin
      merged_d[8*i +: 8] = (2'(i) >= off_q) ? src0_d[8*i +: 8] : i_bus_rdata[8*i +: 8];
    end
    for (int i = 0; i < 4; i++) begin
      rlane_d = 2'(i) + off_q;
      rot_d[8*i +: 8] = merged_d[8*rlane_d +: 8];
    end
    case (len_q)
      2'b00:   load_res_d = {{24{signed_q & rot_d[7]}}, rot_d[7:0]};
      2'b01:   load_res_d = {{16{signed_q & rot_d[15]}}, rot_d[15:0]};
      default: load_res_d = rot_d;
    endcase
  end

  // Sequencer FSM with all outputs registered.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q     <= S_IDLE;
      we_q        <= 1'b0;
      signed_q    <= 1'b0;
      off_q       <= 2'b00;
      len_q       <= 2'b00;
      hi_mask_q   <= 4'b0000;
      rd0_q       <= 32'h0;
      bus_valid_q <= 1'b0;
      bus_addr_q  <= 32'h0;
      bus_we_q    <= 4'b0000;
      bus_wdata_q <= 32'h0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 32'h0;
      rsp_err_q   <= 1'b0;
      busy_q      <= 1'b0;
      req_ready_q <= 1'b1;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (i_req_valid) begin
            we_q        <= i_req_we;
            signed_q    <= i_req_signed;
            off_q       <= i_req_addr[1:0];
            len_q       <= i_req_length;
            hi_mask_q   <= mask_d[7:4];
            busy_q      <= 1'b1;
            req_ready_q <= 1'b0;
            if (err_d) begin
              state_q     <= S_RESP;
              rsp_valid_q <= 1'b1;
              rsp_err_q   <= 1'b1;
              rsp_rdata_q <= 32'h0;
            end else begin
              state_q     <= S_REQ0;
              bus_valid_q <= 1'b1;
              bus_addr_q  <= {i_req_addr[31:2], 2'b00};
              bus_we_q    <= i_req_we ? mask_d[3:0] : 4'b0000;
              bus_wdata_q <= wdata_d;
            end
          end
        end
        S_REQ0: begin
          if (i_bus_ready) begin
            if (we_q && (hi_mask_q != 4'b0000)) begin
              // Second store beat reuses the same rotated data word.
              state_q    <= S_REQ1;
              bus_addr_q <= bus_addr_q + 32'd4;
              bus_we_q   <= hi_mask_q;
            end else if (we_q) begin
              state_q     <= S_RESP;
              bus_valid_q <= 1'b0;
              bus_we_q    <= 4'b0000;
              rsp_valid_q <= 1'b1;
              rsp_rdata_q <= 32'h0;
            end else begin
              state_q     <= S_WAIT0;
              bus_valid_q <= 1'b0;
            end
          end
        end
        S_WAIT0: begin
          if (i_bus_rvalid) begin
            if (hi_mask_q != 4'b0000) begin
              rd0_q       <= i_bus_rdata;
              state_q     <= S_REQ1;
              bus_valid_q <= 1'b1;
              bus_addr_q  <= bus_addr_q + 32'd4;
            end else begin
              state_q     <= S_RESP;
              rsp_valid_q <= 1'b1;
              rsp_rdata_q <= load_res_d;
            end
          end
        end
        S_REQ1: begin
          if (i_bus_ready) begin
            bus_valid_q <= 1'b0;
            bus_we_q    <= 4'b0000;
            if (we_q) begin
              state_q     <= S_RESP;
              rsp_valid_q <= 1'b1;
              rsp_rdata_q <= 32'h0;
            end else begin
              state_q <= S_WAIT1;
            end
          end
        end
        S_WAIT1: begin
          if (i_bus_rvalid) begin
            state_q     <= S_RESP;
            rsp_valid_q <= 1'b1;
            rsp_rdata_q <= load_res_d;
          end
        end
        default: begin
          state_q     <= S_IDLE;
          rsp_valid_q <= 1'b0;
          rsp_rdata_q <= 32'h0;
          rsp_err_q   <= 1'b0;
          busy_q      <= 1'b0;
          req_ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign o_req_ready = req_ready_q;
  assign o_busy      = busy_q;
  assign o_bus_valid = bus_valid_q;
  assign o_bus_addr  = bus_addr_q;
  assign o_bus_we    = bus_we_q;
  assign o_bus_wdata = bus_wdata_q;
  assign o_rsp_valid = rsp_valid_q;
  assign o_rsp_rdata = rsp_rdata_q;
  assign o_rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_lsu_sequencer.sv
// Bench for lsu_sequencer: table of directed transactions plus reset and strict-alignment sequences.
// A second instance with ALLOW_MISALIGNED=0 shares all inputs and is only checked where noted.
module tb_lsu_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0, req_we = 1'b0, req_signed = 1'b0;
  logic [31:0] req_addr = 32'h0, req_wdata = 32'h0;
  logic [1:0]  req_length = 2'b00;
  logic        bus_ready = 1'b1, bus_rvalid = 1'b0;
  logic [31:0] bus_rdata = 32'h0;

  logic        req_ready, busy, bus_valid, rsp_valid, rsp_err;
  logic [31:0] bus_addr, bus_wdata, rsp_rdata;
  logic [3:0]  bus_we;

  logic        d0_req_ready, d0_busy, d0_bus_valid, d0_rsp_valid, d0_rsp_err;
  logic [31:0] d0_bus_addr, d0_bus_wdata, d0_rsp_rdata;
  logic [3:0]  d0_bus_we;

  always #5 clk = ~clk;

  lsu_sequencer #(.ALLOW_MISALIGNED(1'b1)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_req_valid(req_valid), .o_req_ready(req_ready),
    .i_req_we(req_we), .i_req_addr(req_addr), .i_req_wdata(req_wdata),
    .i_req_length(req_length), .i_req_signed(req_signed), .o_busy(busy),
    .o_bus_valid(bus_valid), .i_bus_ready(bus_ready), .o_bus_addr(bus_addr),
    .o_bus_we(bus_we), .o_bus_wdata(bus_wdata), .i_bus_rvalid(bus_rvalid),
    .i_bus_rdata(bus_rdata), .o_rsp_valid(rsp_valid), .o_rsp_rdata(rsp_rdata),
    .o_rsp_err(rsp_err)
  );

  lsu_sequencer #(.ALLOW_MISALIGNED(1'b0)) dut0 (
    .i_clk(clk), .i_rst_n(rst_n), .i_req_valid(req_valid), .o_req_ready(d0_req_ready),
    .i_req_we(req_we), .i_req_addr(req_addr), .i_req_wdata(req_wdata),
    .i_req_length(req_length), .i_req_signed(req_signed), .o_busy(d0_busy),
    .o_bus_valid(d0_bus_valid), .i_bus_ready(bus_ready), .o_bus_addr(d0_bus_addr),
    .o_bus_we(d0_bus_we), .o_bus_wdata(d0_bus_wdata), .i_bus_rvalid(bus_rvalid),
    .i_bus_rdata(bus_rdata), .o_rsp_valid(d0_rsp_valid), .o_rsp_rdata(d0_rsp_rdata),
    .o_rsp_err(d0_rsp_err)
  );

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  len;
    logic        sgn;
    logic [31:0] rd0;
    logic [31:0] rd1;
    int          stall;
    int          lat;
    int          beats;
    logic [31:0] a0;
    logic [3:0]  we0;
    logic [31:0] wd0;
    logic [31:0] a1;
    logic [3:0]  we1;
    logic [31:0] rdata;
    logic        err;
  } vec_t;

  int total = 0;
  int bad   = 0;

  int d0_lat;
  logic d0_err;
  logic d0_bus;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Drives one request and acts as the bus: ready after optional stall, rvalid one cycle after each read beat.
  task automatic run_txn(input vec_t v, input string tag);
    int c, nbeats, stall_left;
    bit got, pend;
    logic [31:0] ba [2];
    logic [3:0]  bw [2];
    logic [31:0] bd [2];
    ba[0] = 32'h0; ba[1] = 32'h0; bw[0] = 4'h0; bw[1] = 4'h0; bd[0] = 32'h0; bd[1] = 32'h0;
    @(negedge clk);
    req_we = v.we; req_addr = v.addr; req_wdata = v.wdata;
    req_length = v.len; req_signed = v.sgn; req_valid = 1'b1;
    bus_ready = 1'b1; bus_rvalid = 1'b0;
    chk({tag, " ready_at_accept"}, {31'h0, req_ready}, 32'h1);
    c = 0; nbeats = 0; got = 0; pend = 0; stall_left = v.stall;
    d0_lat = -1; d0_err = 1'b0; d0_bus = 1'b0;
    while (!got && c < 60) begin
      @(negedge clk);
      c++;
      req_valid = 1'b0;
      bus_rvalid = 1'b0;
      if (pend) begin
        bus_rvalid = 1'b1;
        bus_rdata = (nbeats == 1) ? v.rd0 : v.rd1;
        pend = 0;
      end
      if (d0_rsp_valid && d0_lat < 0) begin
        d0_lat = c;
        d0_err = d0_rsp_err;
      end
      if (d0_bus_valid) d0_bus = 1'b1;
      if (rsp_valid) begin
        got = 1;
      end else begin
        chk({tag, " busy_mid"}, {30'h0, busy, req_ready}, 32'h2);
        if (bus_valid) begin
          if (stall_left > 0) begin
            bus_ready = 1'b0;
            stall_left--;
            chk({tag, " stall_addr"}, bus_addr, v.a0);
            chk({tag, " stall_we"}, {28'h0, bus_we}, {28'h0, v.we0});
            chk({tag, " stall_wdata"}, bus_wdata, v.wd0);
          end else begin
            bus_ready = 1'b1;
            if (nbeats < 2) begin
              ba[nbeats] = bus_addr; bw[nbeats] = bus_we; bd[nbeats] = bus_wdata;
            end
            nbeats++;
            pend = !v.we;
          end
        end
      end
    end
    bus_rvalid = 1'b0;
    bus_ready = 1'b1;
    if (!got) begin
      total++; bad++;
      $display("FAIL %s timeout: no response within %0d cycles", tag, c);
    end else begin
      chk({tag, " latency"}, c, v.lat);
      chk({tag, " beats"}, nbeats, v.beats);
      chk({tag, " rdata"}, rsp_rdata, v.rdata);
      chk({tag, " err"}, {31'h0, rsp_err}, {31'h0, v.err});
      if (v.beats > 0) begin
        chk({tag, " addr0"}, ba[0], v.a0);
        chk({tag, " we0"}, {28'h0, bw[0]}, {28'h0, v.we0});
        if (v.we) chk({tag, " wdata0"}, bd[0], v.wd0);
      end
      if (v.beats > 1) begin
        chk({tag, " addr1"}, ba[1], v.a1);
        chk({tag, " we1"}, {28'h0, bw[1]}, {28'h0, v.we1});
        if (v.we) chk({tag, " wdata1"}, bd[1], v.wd0);
      end
      @(negedge clk);
      chk({tag, " rsp_one_cycle"}, {29'h0, rsp_valid, req_ready, busy}, 32'h2);
    end
  endtask

  vec_t vecs [12];

  initial begin
    //          we    addr          wdata         len    sgn   rd0           rd1           st lat bt a0            we0      wd0           a1            we1      rdata         err
    vecs[0]  = '{1'b0, 32'h00001000, 32'h0,        2'b10, 1'b0, 32'hDEADBEEF, 32'h0,        0, 3, 1, 32'h00001000, 4'b0000, 32'h0,        32'h0,        4'b0000, 32'hDEADBEEF, 1'b0};
    vecs[1]  = '{1'b0, 32'h00001003, 32'h0,        2'b00, 1'b1, 32'h80123456, 32'h0,        0, 3, 1, 32'h00001000, 4'b0000, 32'h0,        32'h0,        4'b0000, 32'hFFFFFF80, 1'b0};
    vecs[2]  = '{1'b0, 32'h00001003, 32'h0,        2'b00, 1'b0, 32'h80123456, 32'h0,        0, 3, 1, 32'h00001000, 4'b0000, 32'h0,        32'h0,        4'b0000, 32'h00000080, 1'b0};
    vecs[3]  = '{1'b0, 32'h00001002, 32'h0,        2'b01, 1'b1, 32'h80123456, 32'h0,        0, 3, 1, 32'h00001000, 4'b0000, 32'h0,        32'h0,        4'b0000, 32'hFFFF8012, 1'b0};
    vecs[4]  = '{1'b0, 32'h00001002, 32'h0,        2'b10, 1'b0, 32'hDDCCBBAA, 32'h44332211, 0, 5, 2, 32'h00001000, 4'b0000, 32'h0,        32'h00001004, 4'b0000, 32'h2211DDCC, 1'b0};
    vecs[5]  = '{1'b1, 32'h00001003, 32'h0000BEEF, 2'b01, 1'b0, 32'h0,        32'h0,        0, 3, 2, 32'h00001000, 4'b1000, 32'hEF0000BE, 32'h00001004, 4'b0001, 32'h0,        1'b0};
    vecs[6]  = '{1'b1, 32'h00002000, 32'h12345678, 2'b10, 1'b0, 32'h0,        32'h0,        5, 7, 1, 32'h00002000, 4'b1111, 32'h12345678, 32'h0,        4'b0000, 32'h0,        1'b0};
    vecs[7]  = '{1'b0, 32'h00001000, 32'h0,        2'b11, 1'b0, 32'h0,        32'h0,        0, 1, 0, 32'h0,        4'b0000, 32'h0,        32'h0,        4'b0000, 32'h0,        1'b1};
    vecs[8]  = '{1'b0, 32'hFFFFFFFF, 32'h0,        2'b01, 1'b0, 32'hAB000000, 32'h000000CD, 0, 5, 2, 32'hFFFFFFFC, 4'b0000, 32'h0,        32'h00000000, 4'b0000, 32'h0000CDAB, 1'b0};
    vecs[9]  = '{1'b1, 32'h00001001, 32'h000000A5, 2'b00, 1'b0, 32'h0,        32'h0,        0, 2, 1, 32'h00001000, 4'b0010, 32'h0000A500, 32'h0,        4'b0000, 32'h0,        1'b0};
    vecs[10] = '{1'b0, 32'h00001000, 32'h0,        2'b01, 1'b1, 32'h1234F00D, 32'h0,        0, 3, 1, 32'h00001000, 4'b0000, 32'h0,        32'h0,        4'b0000, 32'hFFFFF00D, 1'b0};
    vecs[11] = '{1'b1, 32'h00001001, 32'h11223344, 2'b10, 1'b0, 32'h0,        32'h0,        0, 3, 2, 32'h00001000, 4'b1110, 32'h22334411, 32'h00001004, 4'b0001, 32'h0,        1'b0};

    // Reset state
    repeat (3) @(negedge clk);
    chk("reset ctrl", {27'h0, req_ready, busy, bus_valid, rsp_valid, rsp_err}, 32'h10);
    chk("reset bus_addr", bus_addr, 32'h0);
    chk("reset bus_we", {28'h0, bus_we}, 32'h0);
    chk("reset bus_wdata", bus_wdata, 32'h0);
    chk("reset rsp_rdata", rsp_rdata, 32'h0);
    rst_n = 1'b1;

    for (int i = 0; i < 12; i++) begin
      run_txn(vecs[i], $sformatf("vec%0d", i));
    end

    // Strict instance rejects a word-crossing load in one cycle without touching the bus
    run_txn(vecs[4], "strict_mis");
    chk("strict_mis d0_latency", d0_lat, 32'd1);
    chk("strict_mis d0_err", {31'h0, d0_err}, 32'h1);
    chk("strict_mis d0_no_bus", {31'h0, d0_bus}, 32'h0);
    // Strict instance still serves an aligned load normally
    run_txn(vecs[0], "strict_ok");
    chk("strict_ok d0_latency", d0_lat, 32'd3);
    chk("strict_ok d0_err", {31'h0, d0_err}, 32'h0);

    // Reset while waiting for read data, then a stale rvalid
    @(negedge clk);
    req_we = 1'b0; req_addr = 32'h00001000; req_length = 2'b10; req_signed = 1'b0; req_valid = 1'b1;
    bus_ready = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    chk("rst_wait beat", {31'h0, bus_valid}, 32'h1);
    @(negedge clk);
    chk("rst_wait in_wait0", {29'h0, bus_valid, busy, req_ready}, 32'h2);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("rst_wait idle", {29'h0, rsp_valid, busy, req_ready}, 32'h1);
    bus_rvalid = 1'b1; bus_rdata = 32'hCAFEF00D;
    @(negedge clk);
    bus_rvalid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("stale_rvalid c%0d", k), {28'h0, rsp_valid, busy, bus_valid, req_ready}, 32'h1);
      @(negedge clk);
    end

    // Sequencer still works after the abandoned transaction
    run_txn(vecs[1], "post_reset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
